// File: rtl/rt_output_arbiter.sv
// Round-robin arbiter sharing one Corner_Router output port between N_IN requesters
// over the 4-phase req/ack RTPort handshake, with a sticky stall watchdog.
module rt_output_arbiter #(
  parameter int PAYLOAD     = 32,
  parameter int X_BITS      = 1,
  parameter int Y_BITS      = 1,
  parameter int WIDTH       = X_BITS + Y_BITS + 2 + PAYLOAD,
  parameter int N_IN        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         req_i,
  output logic [N_IN-1:0]         ack_i,
  input  logic [N_IN*WIDTH-1:0]   data_i,
  output logic                    req_o,
  output logic [WIDTH-1:0]        data_o,
  input  logic                    ack_o,
  output logic [N_IN-1:0]         grant_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] T_LIM = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_IN-1:0]   w_sreq;
  logic              w_sack;
  logic [IW-1:0]     r_ptr, r_gidx, w_pick;
  logic              w_found, w_grant_en, w_sent, w_done;
  logic [WIDTH-1:0]  r_data;
  logic              r_req, r_to;
  logic [N_IN-1:0]   r_ack, r_grant;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  w_din [N_IN];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sreq = req_i;
      assign w_sack = ack_o;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][N_IN-1:0] r_req_sync;
      logic [SYNC_STAGES-1:0]           r_ack_sync;
      // NOTE: async reset sits in the sensitivity list; sequential state uses <= only
      // so every flop samples pre-edge values and the chain shifts by exactly one stage.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_req_sync <= '0;
          r_ack_sync <= '0;
        end else begin
          r_req_sync[0] <= req_i;
          r_ack_sync[0] <= ack_o;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            r_req_sync[s] <= r_req_sync[s-1];
            r_ack_sync[s] <= r_ack_sync[s-1];
          end
        end
      end
      assign w_sreq = r_req_sync[SYNC_STAGES-1];
      assign w_sack = r_ack_sync[SYNC_STAGES-1];
    end

    for (genvar k = 0; k < N_IN; k++) begin : g_din
      assign w_din[k] = data_i[k*WIDTH +: WIDTH];
    end
  endgenerate

  // First active request at or after the pointer, wrapping modulo N_IN.
  always_comb begin
    int idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!w_found && w_sreq[idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_sent      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: if (w_found) begin
        w_state_nxt = SEND;
        w_grant_en  = 1'b1;
      end
      SEND: if (w_sack) begin
        w_state_nxt = RELEASE;
        w_sent      = 1'b1;
      end
      RELEASE: if (!w_sreq[r_gidx] && !w_sack) begin
        w_state_nxt = IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_req   <= 1'b0;
      r_ack   <= '0;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_grant_en) begin
        r_data  <= w_din[w_pick];
        r_req   <= 1'b1;
        r_grant <= N_IN'(1) << w_pick;
        r_gidx  <= w_pick;
      end
      if (w_sent) begin
        r_req <= 1'b0;
        r_ack <= r_grant;
      end
      if (w_done) begin
        r_ack   <= '0;
        r_grant <= '0;
        r_ptr   <= (r_gidx == IW'(N_IN - 1)) ? '0 : r_gidx + 1'b1;
      end
    end
  end

  // Stall watchdog: cleared on grant, saturates at the limit, flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else if (w_grant_en) begin
      r_cnt <= '0;
    end else if (TIMEOUT_CYC > 0 && r_state != IDLE) begin
      if (r_cnt != T_LIM)          r_cnt <= r_cnt + 1'b1;
      if (r_cnt == T_LIM - 1'b1)   r_to  <= 1'b1;
    end
  end

  assign data_o    = r_data;
  assign req_o     = r_req;
  assign ack_i     = r_ack;
  assign grant_o   = r_grant;
  assign busy_o    = (r_state != IDLE);
  assign timeout_o = r_to;

endmodule
